// File: rtl/aud_play_ctrl_if.sv
// rtl/aud_play_ctrl_if.sv - SRAM read port between the playback sequencer and the sample SRAM
interface aud_play_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_rd;
  logic [15:0]       sram_data;

  modport master (output sram_addr, output sram_rd, input sram_data);
  modport slave  (input sram_addr, input sram_rd, output sram_data);
endinterface

// File: rtl/aud_play_ctrl.sv
// rtl/aud_play_ctrl.sv - SRAM-to-AudPlayer playback sequencer with pause/stop and variable speed
module aud_play_ctrl #(
  parameter int ADDR_W = 20,
  parameter int RD_LAT = 2
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_daclrck,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic              i_slow,
  input  logic [2:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  aud_play_ctrl_if.master   sram,
  output logic [15:0]       o_dac_data,
  output logic              o_player_en,
  output logic [2:0]        o_state,
  output logic              o_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    PLAY  = 3'd3,
    PAUSE = 3'd4
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic [15:0]       dac;
  logic              en;
  logic              done;
  logic [2:0]        hold;
  logic              pend_pause;
  logic              lrck_prev;
  logic [2:0]        lat;

  logic              frame_rise;
  logic              mode_fast;
  logic              mode_slow;
  logic [ADDR_W:0]   step;
  logic [ADDR_W:0]   next;

  assign frame_rise = ~lrck_prev & i_daclrck;
  // Both or neither speed select means normal speed.
  assign mode_fast  = i_fast & ~i_slow;
  assign mode_slow  = i_slow & ~i_fast;

  always_comb begin
    step = (ADDR_W+1)'(1);
    if (mode_fast) step = (ADDR_W+1)'(i_speed) + (ADDR_W+1)'(1);
  end

  // One extra bit so the end-of-clip compare can never be fooled by wrap.
  assign next = {1'b0, addr} + step;

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      rd         <= 1'b0;
      dac        <= '0;
      en         <= 1'b0;
      done       <= 1'b0;
      hold       <= '0;
      pend_pause <= 1'b0;
      lrck_prev  <= 1'b1;
      lat        <= '0;
    end else begin
      lrck_prev <= i_daclrck;
      rd        <= 1'b0;
      done      <= 1'b0;
      if (i_stop && state != IDLE) begin
        state      <= IDLE;
        addr       <= '0;
        hold       <= '0;
        pend_pause <= 1'b0;
        dac        <= '0;
        en         <= 1'b0;
        lat        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start) begin
              state <= FETCH;
              addr  <= '0;
              rd    <= 1'b1;
            end
          end
          FETCH: begin
            if (i_pause) pend_pause <= 1'b1;
            lat   <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (lat == LAT_LAST) begin
              dac <= sram.sram_data;
              if (pend_pause || i_pause) begin
                state      <= PAUSE;
                en         <= 1'b0;
                pend_pause <= 1'b0;
              end else begin
                state <= PLAY;
                en    <= 1'b1;
              end
            end else begin
              lat <= lat + 3'd1;
              if (i_pause) pend_pause <= 1'b1;
            end
          end
          PLAY: begin
            if (i_pause) begin
              state <= PAUSE;
              en    <= 1'b0;
            end else if (frame_rise) begin
              if (mode_slow && hold < i_speed) begin
                hold <= hold + 3'd1;
              end else begin
                if (mode_slow) hold <= '0;
                if (next > {1'b0, i_end_addr}) begin
                  addr  <= '0;
                  done  <= 1'b1;
                  en    <= 1'b0;
                  state <= IDLE;
                end else begin
                  addr  <= next[ADDR_W-1:0];
                  rd    <= 1'b1;
                  state <= FETCH;
                end
              end
            end
          end
          PAUSE: begin
            if (i_start && !i_pause) begin
              state <= FETCH;
              rd    <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign sram.sram_addr = addr;
  assign sram.sram_rd   = rd;
  assign o_dac_data     = dac;
  assign o_player_en    = en;
  assign o_state        = state;
  assign o_done         = done;

endmodule

// File: tb/tb_aud_play_ctrl.sv
// tb/tb_aud_play_ctrl.sv - self-checking bench for aud_play_ctrl against a frame-level playback model
module tb_aud_play_ctrl;
  localparam int ADDR_W = 20;
  localparam int RD_LAT = 2;
  localparam int HALF   = 16;

  logic              bclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              lrck = 1'b1;
  logic              start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic              fast = 1'b0, slow = 1'b0;
  logic [2:0]        speed = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [15:0]       dac;
  logic              en, done;
  logic [2:0]        state;

  aud_play_ctrl_if #(.ADDR_W(ADDR_W)) sif();

  aud_play_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .i_bclk(bclk), .i_rst_n(rst_n), .i_daclrck(lrck),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_fast(fast), .i_slow(slow), .i_speed(speed), .i_end_addr(end_addr),
    .sram(sif),
    .o_dac_data(dac), .o_player_en(en), .o_state(state), .o_done(done)
  );

  always #5 bclk = ~bclk;

  initial begin
    forever begin
      repeat (HALF) @(posedge bclk);
      #1 lrck = ~lrck;
    end
  end

  // SRAM: data is only valid RD_LAT cycles after a read strobe; otherwise junk.
  logic [15:0] mem [64];
  logic [15:0] pipe [RD_LAT];
  always @(posedge bclk) begin
    for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= sif.sram_rd ? mem[sif.sram_addr[5:0]] : 16'hDEAD;
  end
  assign sif.sram_data = pipe[RD_LAT-1];

  int tests = 0, fails = 0;
  int done_cnt = 0;
  bit run_active = 0, paused = 0, en_hold = 0;
  logic [15:0] exp_samples [$];
  int          exp_reads [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Frame-level model: list of addresses fetched and sample heard on each frame.
  task automatic build(input int end_a, input bit f, input bit s, input int spd);
    int a = 0;
    int stp = (f && !s) ? spd + 1 : 1;
    int rep = (s && !f) ? spd + 1 : 1;
    exp_samples.delete();
    exp_reads.delete();
    while (a <= end_a) begin
      exp_reads.push_back(a);
      for (int r = 0; r < rep; r++) exp_samples.push_back(mem[a]);
      a += stp;
    end
  endtask

  initial begin : cmp
    logic lr_q, rd_q, done_q;
    lr_q = 1'b1; rd_q = 1'b0; done_q = 1'b0;
    forever begin
      @(negedge bclk);
      if (rst_n) begin
        if (done) begin
          chk("done_when_expected", 32'(run_active && exp_samples.size() == 0 && !paused), 1);
          chk("done_single_cycle", 32'(done_q), 0);
          done_cnt++;
          en_hold = 0;
        end
        if (sif.sram_rd) begin
          chk("rd_single_cycle", 32'(rd_q), 0);
          if (run_active) begin
            if (exp_reads.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_addr", 32'(sif.sram_addr), 32'(exp_reads.pop_front()));
          end
        end
        if (en_hold) chk("player_en_held", 32'(en), 1);
        if (lr_q && !lrck && run_active) begin
          if (paused) chk("en_paused", 32'(en), 0);
          else if (exp_samples.size() > 0) begin
            chk("frame_en", 32'(en), 1);
            chk("frame_data", 32'(dac), 32'(exp_samples.pop_front()));
            en_hold = 1;
          end else chk("en_after_end", 32'(en), 0);
        end
      end
      lr_q = lrck; rd_q = sif.sram_rd; done_q = done;
    end
  end

  task automatic pulse_start();
    @(posedge bclk); #1 start = 1'b1;
    @(posedge bclk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge bclk);
      n++;
    end
    chk("run_timeout", 32'(done_cnt != d0), 1);
    repeat (2) @(negedge bclk);
    chk("end_reads_left", 32'(exp_reads.size()), 0);
    chk("end_samples_left", 32'(exp_samples.size()), 0);
    chk("end_state", 32'(state), 0);
    chk("end_addr", 32'(sif.sram_addr), 0);
    chk("end_en", 32'(en), 0);
    run_active = 0;
  endtask

  task automatic set_mode(input int end_a, input bit f, input bit s, input int spd);
    fast = f; slow = s; speed = 3'(spd); end_addr = ADDR_W'(end_a);
  endtask

  task automatic run_clip(input int end_a, input bit f, input bit s, input int spd);
    set_mode(end_a, f, s, spd);
    build(end_a, f, s, spd);
    @(posedge lrck);
    run_active = 1; paused = 0;
    pulse_start();
    wait_done((exp_samples.size() + 2) * 2 * HALF + 64);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'(i);
    #7;
    chk("rst_state", 32'(state), 0);
    chk("rst_dac", 32'(dac), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_rd", 32'(sif.sram_rd), 0);
    chk("rst_addr", 32'(sif.sram_addr), 0);
    chk("rst_done", 32'(done), 0);
    repeat (3) @(posedge bclk);
    #1 rst_n = 1'b1;

    // Normal play
    mem[0] = 16'hBA0E; mem[1] = 16'h5E3A; mem[2] = 16'hEA19; mem[3] = 16'hF815;
    build(3, 0, 0, 0);
    chk("model_n_len", 32'(exp_samples.size()), 4);
    chk("model_n0", 32'(exp_samples[0]), 32'hBA0E);
    chk("model_n3", 32'(exp_samples[3]), 32'hF815);
    run_clip(3, 0, 0, 0);

    // Fast 3x
    for (int i = 0; i < 64; i++) mem[i] = 16'(i);
    build(9, 1, 0, 2);
    chk("model_f_reads", 32'(exp_reads.size()), 4);
    chk("model_f1", 32'(exp_reads[1]), 3);
    chk("model_f3", 32'(exp_samples[3]), 9);
    run_clip(9, 1, 0, 2);

    // Slow 4x
    build(1, 0, 1, 3);
    chk("model_s_len", 32'(exp_samples.size()), 8);
    chk("model_s_reads", 32'(exp_reads.size()), 2);
    chk("model_s4", 32'(exp_samples[4]), 1);
    run_clip(1, 0, 1, 3);

    // Pause during WAIT at addr 5, then resume
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    set_mode(9, 0, 0, 0);
    exp_samples.delete(); exp_reads.delete();
    for (int i = 0; i <= 5; i++) exp_reads.push_back(i);
    for (int i = 0; i <= 4; i++) exp_samples.push_back(mem[i]);
    @(posedge lrck);
    run_active = 1; paused = 0;
    pulse_start();
    begin
      int n = 0;
      while (!(sif.sram_rd && sif.sram_addr == 5) && n < 12 * HALF) begin
        @(negedge bclk);
        n++;
      end
      chk("pause_fetch5_seen", 32'(n < 12 * HALF), 1);
    end
    @(posedge bclk); #1 pause = 1'b1; paused = 1; en_hold = 0;
    @(posedge bclk); #1 pause = 1'b0;
    repeat (4) @(negedge bclk);
    chk("pause_state", 32'(state), 4);
    chk("pause_dac", 32'(dac), 32'(mem[5]));
    chk("pause_en", 32'(en), 0);
    chk("pause_addr", 32'(sif.sram_addr), 5);
    @(posedge lrck);
    for (int i = 5; i <= 9; i++) begin
      exp_reads.push_back(i);
      exp_samples.push_back(mem[i]);
    end
    paused = 0;
    pulse_start();
    wait_done(8 * 2 * HALF);

    // Stop together with pause mid-PLAY, then restart
    build(3, 0, 0, 0);
    @(posedge lrck);
    run_active = 1; paused = 0;
    pulse_start();
    @(negedge lrck);
    @(negedge lrck);
    @(posedge bclk); #1;
    chk("stop_pre_state", 32'(state), 3);
    run_active = 0; en_hold = 0;
    exp_samples.delete(); exp_reads.delete();
    stop = 1'b1; pause = 1'b1;
    @(posedge bclk); #1 stop = 1'b0; pause = 1'b0;
    chk("stop_state", 32'(state), 0);
    chk("stop_addr", 32'(sif.sram_addr), 0);
    chk("stop_dac", 32'(dac), 0);
    chk("stop_en", 32'(en), 0);
    repeat (3 * HALF) @(negedge bclk);
    run_clip(3, 0, 0, 0);

    // Randomized clips
    for (int k = 0; k < 8; k++) begin
      int mode, spd, e;
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      mode = $urandom_range(0, 3);
      spd  = $urandom_range(0, 7);
      e    = $urandom_range(0, 15);
      if (mode == 2) begin
        spd = $urandom_range(0, 3);
        e   = $urandom_range(0, 3);
      end
      run_clip(e, mode[0], mode[1], spd);
    end

    // Async reset mid-WAIT
    set_mode(3, 0, 0, 0);
    @(posedge lrck);
    pulse_start();
    begin
      int n = 0;
      while (!sif.sram_rd && n < 8) begin
        @(negedge bclk);
        n++;
      end
      chk("rst_fetch_seen", 32'(sif.sram_rd), 1);
    end
    @(posedge bclk); #3 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_dac", 32'(dac), 0);
    chk("arst_en", 32'(en), 0);
    chk("arst_rd", 32'(sif.sram_rd), 0);
    repeat (2) @(posedge bclk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge bclk);
      chk("post_rst_dac", 32'(dac), 0);
      chk("post_rst_state", 32'(state), 0);
    end

    // Single-sample clip after recovery
    run_clip(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aud_play_ctrl.md
Name: aud_play_ctrl

Overview:
- Playback sequencer for the audio path: fetches 16-bit samples from the external SRAM and presents them to the I2S player (AudPlayer) one per LRCK frame.
- Drives the player's enable and data inputs.
- Implements start/pause/stop and variable-speed playback: fast playback by sample skip, slow playback by zero-order hold.
- Sits between the top-level key/FSM logic and the SRAM/AudPlayer pair, in the i_bclk domain.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- RD_LAT, 2, i_bclk cycles from o_sram_rd to valid i_sram_data (1..4).

Ports:
- i_bclk  in  1  bit clock; all logic on its rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_daclrck  in  1  codec LR clock (low = left/sample slot)
- i_start  in  1  one-cycle pulse: start from IDLE or resume from PAUSE
- i_pause  in  1  one-cycle pulse: pause
- i_stop  in  1  one-cycle pulse: stop and rewind
- i_fast  in  1  fast-mode select
- i_slow  in  1  slow-mode select
- i_speed  in  3  speed factor minus 1 (0..7 → 1x..8x)
- i_end_addr  in  ADDR_W  last valid sample address (inclusive)
- o_sram_addr  out  ADDR_W  read address
- o_sram_rd  out  1  read strobe, one cycle per fetch
- i_sram_data  in  16  read data, valid RD_LAT cycles after o_sram_rd
- o_dac_data  out  16  sample to AudPlayer i_dac_data
- o_player_en  out  1  to AudPlayer i_en
- o_state  out  3  current state encoding
- o_done  out  1  one-cycle pulse at natural end of clip

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE.
  - o_sram_addr=0, o_sram_rd=0, o_dac_data=0, o_player_en=0, o_done=0.
  - Hold counter=0, pending-pause=0, daclrck history reg=1.
  - Reset mid-fetch discards the read.
- Edge detection: daclrck registered once. Rising edge (prev=0, now=1) marks a frame boundary and is used for address advance. The player samples data at the falling edge.
- States: IDLE=0, FETCH=1, WAIT=2, PLAY=3, PAUSE=4.
- IDLE:
  - i_start → FETCH with addr=0.
  - i_pause is ignored.
  - o_player_en=0.
- FETCH:
  - o_sram_rd=1 for exactly this cycle; o_sram_addr stable.
  - Next state is WAIT.
- WAIT:
  - Count RD_LAT cycles, then latch i_sram_data into o_dac_data.
  - Go to PLAY, or to PAUSE if pending-pause is set (then clear it).
- PLAY:
  - o_player_en=1; o_dac_data held.
  - On the daclrck rising edge, sample i_fast, i_slow and i_speed, then:
    - normal (both or neither of i_fast/i_slow): step=1.
    - fast: step=i_speed+1.
    - slow: if hold counter < i_speed, increment it, keep addr, stay in PLAY (no fetch). Otherwise clear it, step=1.
  - next = addr + step, computed at ADDR_W+1 bits.
  - If next > i_end_addr: addr=0, o_done=1 for one cycle, o_player_en=0, go to IDLE.
  - Otherwise: addr=next, go to FETCH.
- PAUSE:
  - o_player_en=0; addr, hold counter and o_dac_data are retained.
  - i_start → FETCH, re-reading the current addr.
- i_pause in FETCH/WAIT sets pending-pause, so the read completes first. i_pause in PLAY goes to PAUSE immediately.
- i_stop (any state except IDLE):
  - Next state IDLE; addr=0, hold counter=0, pending-pause=0.
  - o_dac_data=0, o_player_en=0, o_done=0.
  - An in-flight read is discarded.
- Simultaneous pulses: priority i_stop > i_pause > i_start.
- A frame edge in the same cycle as i_pause in PLAY: pause wins, addr does not advance.
- Timing requirement: RD_LAT+2 cycles must be shorter than the daclrck high half, so new data is stable before the falling edge.
- i_end_addr=0 plays one sample, then finishes.
- Address wrap: never occurs, because the comparison is done at ADDR_W+1 bits.

Test Plan:
- Normal play: preload mem[0..3]={BA0E,5E3A,EA19,F815}, end=3, start → o_dac_data sequence BA0E,5E3A,EA19,F815, one sample per frame. Each o_sram_rd is followed RD_LAT cycles later by the latch. o_done pulses after the 4th frame boundary; addr=0; state IDLE.
- Fast 3x: mem[i]=i, end=9, i_fast=1, i_speed=2 → samples 0,3,6,9. o_done at the frame after 9. Exactly 4 o_sram_rd pulses.
- Slow 4x: i_slow=1, i_speed=3, end=1 → sample 0 held 4 frames, then sample 1 held 4 frames. Only 2 reads; o_player_en stays 1 throughout.
- Pause/resume: pause at addr=5 during WAIT → read completes, then PAUSE with o_dac_data=mem[5] and o_player_en=0. Start → re-fetch addr 5, play resumes at 5 then 6.
- Stop, plus stop+pause in the same cycle mid-PLAY → IDLE, addr=0, o_dac_data=0, no o_done. A following start plays from mem[0].
- Async reset asserted during WAIT, between clock edges → all outputs zero immediately. No latch of pending data after release.
